// File: rtl/mem_stage_ws.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_ws
//  Purpose  : MEM pipeline stage with internal data memory. Handles byte, half
//             and word loads/stores with sign/zero extension. WAIT_STATES
//             selects extra cycles per access, and freeze stalls upstream
//             stages while an access is in flight.
//  Options  : MISALIGN_CHECK_EN - when defined, misaligned half/word accesses
//             are suppressed and flagged on mem_fault.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stage_ws #(
   parameter int WORD_LEN    = 32,
   parameter int DEPTH       = 64,
   parameter int BASE_ADDR   = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                MEM_R_EN,
   input  logic                MEM_W_EN,
   input  logic [1:0]          MEM_SIZE,
   input  logic                MEM_SIGNED,
   input  logic [WORD_LEN-1:0] ALU_res,
   input  logic [WORD_LEN-1:0] ST_value,
   output logic [WORD_LEN-1:0] dataMem_out,
   output logic                freeze,
   output logic                mem_fault
);

   localparam int                  c_idx_w = $clog2(DEPTH);
   localparam logic [WORD_LEN-1:0] c_base  = WORD_LEN'(BASE_ADDR);

   // Storage, one 32-bit word per entry, four little-endian byte lanes
   logic [WORD_LEN-1:0] r_mem [DEPTH];

   // Access currently being completed (live inputs or latched copy)
   logic                w_fire;
   logic                w_acc_rd;
   logic                w_acc_wr;
   logic [1:0]          w_acc_size;
   logic                w_acc_signed;
   logic [WORD_LEN-1:0] w_acc_addr;
   logic [WORD_LEN-1:0] w_acc_wdata;

   logic [c_idx_w-1:0]  w_idx;
   logic [WORD_LEN-1:0] w_rword;
   logic [3:0]          w_be;
   logic [WORD_LEN-1:0] w_wdata;
   logic [WORD_LEN-1:0] w_rdata;
   logic [7:0]          w_lane_b;
   logic [15:0]         w_lane_h;
   logic                w_misalign;

   // Out-of-range addresses simply wrap modulo DEPTH
   assign w_idx   = c_idx_w'((w_acc_addr - c_base) >> 2);
   assign w_rword = r_mem[w_idx];

   generate
      if (WAIT_STATES == 0) begin : g_no_wait
         // Single-cycle access straight from the live request
         assign w_fire       = MEM_R_EN | MEM_W_EN;
         assign w_acc_rd     = MEM_R_EN;
         assign w_acc_wr     = MEM_W_EN;
         assign w_acc_size   = MEM_SIZE;
         assign w_acc_signed = MEM_SIGNED;
         assign w_acc_addr   = ALU_res;
         assign w_acc_wdata  = ST_value;
         assign freeze       = 1'b0;
      end else begin : g_wait
         localparam logic [0:0] c_idle = 1'b0;
         localparam logic [0:0] c_busy = 1'b1;

         logic [0:0]          r_state;
         logic [3:0]          r_cnt;
         logic                r_rd;
         logic                r_wr;
         logic [1:0]          r_size;
         logic                r_signed;
         logic [WORD_LEN-1:0] r_addr;
         logic [WORD_LEN-1:0] r_wdata;
         logic                w_req;

         assign w_req = MEM_R_EN | MEM_W_EN;

         // Request capture and wait-state countdown; inputs ignored while busy
         always_ff @(posedge clk) begin
            if (rst) begin
               r_state  <= c_idle;
               r_cnt    <= 4'd0;
               r_rd     <= 1'b0;
               r_wr     <= 1'b0;
               r_size   <= 2'b00;
               r_signed <= 1'b0;
               r_addr   <= '0;
               r_wdata  <= '0;
            end else if (r_state == c_idle) begin
               if (w_req) begin
                  r_rd     <= MEM_R_EN;
                  r_wr     <= MEM_W_EN;
                  r_size   <= MEM_SIZE;
                  r_signed <= MEM_SIGNED;
                  r_addr   <= ALU_res;
                  r_wdata  <= ST_value;
                  r_cnt    <= 4'(WAIT_STATES - 1);
                  r_state  <= c_busy;
               end
            end else begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_state <= c_idle;
               end
            end
         end

         assign w_fire       = (r_state == c_busy) && (r_cnt == 4'd0);
         assign w_acc_rd     = r_rd;
         assign w_acc_wr     = r_wr;
         assign w_acc_size   = r_size;
         assign w_acc_signed = r_signed;
         assign w_acc_addr   = r_addr;
         assign w_acc_wdata  = r_wdata;
         assign freeze       = ((r_state == c_idle) && w_req) ||
                               ((r_state == c_busy) && (r_cnt != 4'd0));
      end
   endgenerate

`ifdef MISALIGN_CHECK_EN
   // Half needs bit 0 clear, word needs both low bits clear
   always_comb begin
      w_misalign = 1'b0;
      case (w_acc_size)
         2'b00:   w_misalign = 1'b0;
         2'b01:   w_misalign = w_acc_addr[0];
         default: w_misalign = |w_acc_addr[1:0];
      endcase
   end
`else
   assign w_misalign = 1'b0;
`endif

   // Lane selection: byte enables, replicated store data, extended load data
   always_comb begin
      w_be     = 4'b1111;
      w_wdata  = w_acc_wdata;
      w_lane_b = w_rword[{w_acc_addr[1:0], 3'b000} +: 8];
      w_lane_h = w_rword[{w_acc_addr[1], 4'b0000} +: 16];
      w_rdata  = w_rword;
      case (w_acc_size)
         2'b00: begin
            w_be    = 4'b0001 << w_acc_addr[1:0];
            w_wdata = {4{w_acc_wdata[7:0]}};
            w_rdata = {{(WORD_LEN-8){w_acc_signed & w_lane_b[7]}}, w_lane_b};
         end
         2'b01: begin
            w_be    = w_acc_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{w_acc_wdata[15:0]}};
            w_rdata = {{(WORD_LEN-16){w_acc_signed & w_lane_h[15]}}, w_lane_h};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = w_acc_wdata;
            w_rdata = w_rword;
         end
      endcase
   end

   // Memory clear on reset, lane-masked store on the completing edge
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            r_mem[k] <= '0;
         end
      end else if (w_fire && w_acc_wr && !w_misalign) begin
         for (int l = 0; l < 4; l++) begin
            if (w_be[l]) begin
               r_mem[w_idx][8*l +: 8] <= w_wdata[8*l +: 8];
            end
         end
      end
   end

   // A simultaneous store wins, so the read side stays quiet
   assign dataMem_out = (w_fire && w_acc_rd && !w_acc_wr && !w_misalign) ? w_rdata : '0;
   assign mem_fault   = w_fire & w_misalign;

endmodule
`default_nettype wire

// File: doc/mem_stage_ws.md
Name: mem_stage_ws

Overview:
Parametrised MEM pipeline stage with an internal data memory. Supports byte, half and word loads/stores, sign/zero extension and a configurable wait-state latency. Drives a freeze output that stalls the upstream pipeline while an access is in flight. Sits between EX/MEM and MEM/WB registers; consumes ALU_res as byte address and ST_value as store data.

Parameters:
WORD_LEN, 32, data/address width in bits (fixed at 32 for lane logic).
DEPTH, 64, memory depth in words, power of two.
BASE_ADDR, 1024, byte address that maps to word 0.
WAIT_STATES, 0, extra cycles per access, 0..15.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
MEM_R_EN  in  1  load request
MEM_W_EN  in  1  store request
MEM_SIZE  in  2  00 byte, 01 half, 10 word, 11 treated as word
MEM_SIGNED  in  1  1 = sign-extend sub-word loads, 0 = zero-extend
ALU_res  in  WORD_LEN  byte address
ST_value  in  WORD_LEN  store data, low bits used for sub-word stores
dataMem_out  out  WORD_LEN  load result, extended to WORD_LEN
freeze  out  1  1 = hold upstream stages this cycle
mem_fault  out  1  misalignment flag, see Optional Feature

Behaviour:
- Word index = ((ALU_res - BASE_ADDR) >> 2) mod DEPTH; out-of-range addresses wrap, never fault.
- Little-endian lanes. Byte uses lane ALU_res[1:0]. Half uses ALU_res[1] (ALU_res[0] ignored). Word ignores ALU_res[1:0].
- Stores write only the selected lanes; other lanes keep their value.
- Loads extract the selected lanes and extend per MEM_SIGNED.
- If MEM_R_EN and MEM_W_EN are both high, the store is performed, the read is suppressed and dataMem_out = 0.
- With no load completing, dataMem_out = 0.
- rst: all memory words cleared to 0, FSM to IDLE, counter 0, freeze 0, mem_fault 0, dataMem_out 0.
- rst asserted mid-access aborts the access; a pending store is discarded.
- WAIT_STATES = 0:
  - No FSM activity; freeze is constant 0.
  - Store commits on the edge ending the request cycle.
  - Load data is combinational from the current address, valid in the same cycle.
- WAIT_STATES = W >= 1, two-state FSM:
  - IDLE, request present: freeze = 1. Latch address, size, signed and store data. cnt <= W-1, go to BUSY.
  - IDLE, no request: freeze = 0.
  - BUSY, cnt != 0: freeze = 1, cnt <= cnt-1. Latched values hold; live inputs are ignored.
  - BUSY, cnt == 0: completion cycle. freeze = 0. Load: dataMem_out is driven from the latched address this cycle. Store: commits on this edge. Next state is IDLE.
  - freeze is high for exactly W cycles per access; the access occupies W+1 cycles in total.
  - A request present in the cycle after completion is a new access and restarts the sequence.
- freeze is combinational from state, cnt and request; no dependence on data.

Optional Feature:
- Macro: MISALIGN_CHECK_EN.
- Defined:
  - Half access with ALU_res[0] = 1, or word access with ALU_res[1:0] != 0, is a fault.
  - On a fault: store suppressed, dataMem_out = 0, mem_fault = 1 for the completion cycle (the request cycle when W = 0).
  - Wait-state timing is unchanged by a fault.
- Not defined: mem_fault tied to 0; misaligned low bits are ignored as above.

Test Plan:
- W=0: store word 0xDEADBEEF @1024, then load word @1024 -> dataMem_out = 0xDEADBEEF same cycle, freeze = 0 throughout.
- W=0: store byte 0x80 @1027; signed byte load @1027 -> 0xFFFFFF80; unsigned byte load -> 0x00000080; word load @1024 -> 0x80ADBEEF.
- W=3: load request held -> freeze = 1,1,1 then 0; data valid only in the 4th cycle; a second back-to-back load repeats the same pattern.
- W=2: store in flight with rst pulsed in the BUSY cycle -> FSM returns to IDLE, freeze = 0, memory word reads 0.
- Both enables high, W=0, store 0x12345678 @1028 -> dataMem_out = 0; a later load @1028 returns 0x12345678. Address 1024 + 4*DEPTH aliases word 0.
- MISALIGN_CHECK_EN defined: word store @1025 -> mem_fault = 1 for one cycle, memory unchanged. Undefined: mem_fault stays 0 and the store lands at word 0.
